// File: rtl/dec_16_pkg.sv
// rtl/dec_16_pkg.sv - shared constants and helpers for the dec_16 decoder
//
// Purpose: width constants for the select/output fields and a multi-hot
// detector used by the optional one-hot check in dec_16.
// Ports: none (package).

package dec_16_pkg;

  localparam int DEC_16_SEL_W   = 4;
  localparam int DEC_16_OUT_N   = 16;
  localparam int DEC_2TO4_OUT_N = 4;

  typedef logic [DEC_16_OUT_N-1:0] dec_vec_t;

  // Clearing the lowest set bit leaves a nonzero value only when two or
  // more bits were set.
  function automatic logic multi_hot(input dec_vec_t v);
    dec_vec_t low_cleared;
    low_cleared = v & (v - dec_vec_t'(1));
    return |low_cleared;
  endfunction

endpackage

// File: rtl/dec_2to4.sv
// rtl/dec_2to4.sv - combinational 2-to-4 decoder with active-high enable
//
// Purpose: building block for the two-stage 16-way decode in dec_16.
// Ports:
//   en      in   enable; all outputs low when 0
//   b1, b0  in   select bits, b1 is the MSB
//   y0..y3  out  one-hot decode, yN high when en=1 and {b1,b0}=N

module dec_2to4 (
  input  logic en,
  input  logic b1,
  input  logic b0,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3
);

  assign y0 = en & ~b1 & ~b0;
  assign y1 = en & ~b1 &  b0;
  assign y2 = en &  b1 & ~b0;
  assign y3 = en &  b1 &  b0;

endmodule

// File: rtl/dec_16.sv
// rtl/dec_16.sv - registered 4-to-16 one-hot decoder with enable
//
// Purpose: samples {a3,a2,a1,a0} and ip each rising edge and drives exactly
// one of s0..s15 high (or none when ip=0) from a register bank, so the
// decode appears one cycle after the select is applied.
// Optional feature macro: DEC_16_CHECK_EN adds the sticky onehot_err flag
// and a simulation-time one-hot check.
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset, clears all outputs
//   ip             in   decode enable, active-high
//   a3, a2, a1, a0 in   select bits, a3 is the MSB
//   s0..s15        out  registered one-hot strobes, sN for select value N
//   onehot_err     out  sticky multi-hot flag (DEC_16_CHECK_EN only)

module dec_16
  import dec_16_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ip,
  input  logic a3,
  input  logic a2,
  input  logic a1,
  input  logic a0,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic s4,
  output logic s5,
  output logic s6,
  output logic s7,
  output logic s8,
  output logic s9,
  output logic s10,
  output logic s11,
  output logic s12,
  output logic s13,
  output logic s14,
  output logic s15
`ifdef DEC_16_CHECK_EN
  ,
  output logic onehot_err
`endif
);

  logic [DEC_2TO4_OUT_N-1:0] grp_en;
  dec_vec_t                  dec_next;
  dec_vec_t                  s_q;

  // Group stage: {a3,a2} picks one block of four outputs, gated by ip.
  dec_2to4 u_grp (
    .en (ip),
    .b1 (a3),
    .b0 (a2),
    .y0 (grp_en[0]),
    .y1 (grp_en[1]),
    .y2 (grp_en[2]),
    .y3 (grp_en[3])
  );

  // Output stage: group g covers s(4g) .. s(4g+3), selected by {a1,a0}.
  for (genvar g = 0; g < DEC_2TO4_OUT_N; g++) begin : g_out
    dec_2to4 u_out (
      .en (grp_en[g]),
      .b1 (a1),
      .b0 (a0),
      .y0 (dec_next[4*g+0]),
      .y1 (dec_next[4*g+1]),
      .y2 (dec_next[4*g+2]),
      .y3 (dec_next[4*g+3])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
    end else begin
      s_q <= dec_next;
    end
  end

  assign s0  = s_q[0];
  assign s1  = s_q[1];
  assign s2  = s_q[2];
  assign s3  = s_q[3];
  assign s4  = s_q[4];
  assign s5  = s_q[5];
  assign s6  = s_q[6];
  assign s7  = s_q[7];
  assign s8  = s_q[8];
  assign s9  = s_q[9];
  assign s10 = s_q[10];
  assign s11 = s_q[11];
  assign s12 = s_q[12];
  assign s13 = s_q[13];
  assign s14 = s_q[14];
  assign s15 = s_q[15];

`ifdef DEC_16_CHECK_EN
  logic err_q;

  // Sticky: once the registered strobes are seen multi-hot, hold until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | multi_hot(s_q);
    end
  end

  assign onehot_err = err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!multi_hot(s_q));
    end
  end
`endif

endmodule

// File: tb/tb_dec_16.sv
// tb/tb_dec_16.sv - self-checking bench for dec_16

module tb_dec_16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ip  = 1'b0;
  logic [3:0]  sel = 4'd0;
  wire  [15:0] s;
`ifdef DEC_16_CHECK_EN
  wire         onehot_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_s  = 16'h0;
  bit          primed = 1'b0;

  always #5 clk = ~clk;

  dec_16 dut (
    .clk (clk),
    .rst (rst),
    .ip  (ip),
    .a3  (sel[3]),
    .a2  (sel[2]),
    .a1  (sel[1]),
    .a0  (sel[0]),
    .s0  (s[0]),
    .s1  (s[1]),
    .s2  (s[2]),
    .s3  (s[3]),
    .s4  (s[4]),
    .s5  (s[5]),
    .s6  (s[6]),
    .s7  (s[7]),
    .s8  (s[8]),
    .s9  (s[9]),
    .s10 (s[10]),
    .s11 (s[11]),
    .s12 (s[12]),
    .s13 (s[13]),
    .s14 (s[14]),
    .s15 (s[15])
`ifdef DEC_16_CHECK_EN
    ,
    .onehot_err (onehot_err)
`endif
  );

  // Behavioural model: whatever was sampled at the edge, as a plain shift.
  always @(posedge clk) begin
    if (rst) begin
      exp_s  <= 16'h0;
      primed <= 1'b1;
    end else if (ip) begin
      exp_s  <= 16'h1 << sel;
    end else begin
      exp_s  <= 16'h0;
    end
  end

  // Checked after the inputs have moved for the next cycle, so any
  // combinational leak from inputs to outputs shows up as a mismatch.
  always @(negedge clk) begin
    #3;
    if (primed) begin
      checks++;
      if (s !== exp_s) begin
        errors++;
        $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, s, exp_s);
      end
      checks++;
      if ($countones(s) > 1) begin
        errors++;
        $display("FAIL onehot_count t=%0t got=%h ones=%0d max=1", $time, s, $countones(s));
      end
`ifdef DEC_16_CHECK_EN
      checks++;
      if (onehot_err !== 1'b0) begin
        errors++;
        $display("FAIL onehot_err t=%0t got=%b exp=0", $time, onehot_err);
      end
`endif
    end
  end

  task automatic apply(input logic r, input logic i, input logic [3:0] v);
    @(negedge clk);
    #1;
    rst = r;
    ip  = i;
    sel = v;
  endtask

  task automatic lit(input string name, input logic [15:0] want);
    @(posedge clk);
    #1;
    checks++;
    if (s !== want) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, s, want);
    end
  endtask

  initial begin
    // Reset with ip=1, sel=5 held: outputs must stay clear.
    apply(1'b1, 1'b1, 4'd5);
    lit("reset_clear", 16'h0000);
    apply(1'b1, 1'b1, 4'd5);
    lit("reset_hold", 16'h0000);
    apply(1'b0, 1'b1, 4'd5);
    lit("first_after_reset", 16'h0020);

    // Full sweep, one select per cycle.
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 1'b1, 4'(i));
      if (i == 0)  lit("sweep_sel0", 16'h0001);
      else if (i == 15) lit("sweep_sel15", 16'h8000);
      else lit("sweep_step", 16'h0001 << i);
    end

    // Disable while holding sel=9.
    apply(1'b0, 1'b1, 4'd9);
    lit("disable_pre", 16'h0200);
    apply(1'b0, 1'b0, 4'd9);
    lit("disable_zero", 16'h0000);
    apply(1'b0, 1'b0, 4'd9);
    lit("disable_hold", 16'h0000);

    // Group boundary crossings.
    apply(1'b0, 1'b1, 4'd3);
    lit("bound_s3", 16'h0008);
    apply(1'b0, 1'b1, 4'd4);
    lit("bound_s4", 16'h0010);
    apply(1'b0, 1'b1, 4'd11);
    lit("bound_s11", 16'h0800);
    apply(1'b0, 1'b1, 4'd12);
    lit("bound_s12", 16'h1000);

    // Mid-sweep reset pulse at sel=7.
    apply(1'b0, 1'b1, 4'd5);
    lit("midrst_s5", 16'h0020);
    apply(1'b0, 1'b1, 4'd6);
    lit("midrst_s6", 16'h0040);
    apply(1'b1, 1'b1, 4'd7);
    lit("midrst_clear", 16'h0000);
    apply(1'b0, 1'b1, 4'd8);
    lit("midrst_resume", 16'h0100);
    apply(1'b0, 1'b1, 4'd9);
    lit("midrst_next", 16'h0200);

    // Random run, checked by the model every cycle.
    for (int i = 0; i < 200; i++) begin
      apply(1'b0, 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
    end

    apply(1'b0, 1'b0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
